// File: rtl/mode_coord_if.sv
// Bundle of strobed input events and registered coordinate outputs for mode_coord_ctrl.
interface mode_coord_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        us_valid;
  logic [7:0]  us_dist;
  logic        adc_valid;
  logic [11:0] adc_x;
  logic [11:0] adc_y;
  logic [1:0]  state;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        coord_valid;

  modport master (
    output key_valid, key_code, us_valid, us_dist, adc_valid, adc_x, adc_y,
    input  state, x, y, coord_valid
  );

  modport slave (
    input  key_valid, key_code, us_valid, us_dist, adc_valid, adc_x, adc_y,
    output state, x, y, coord_valid
  );
endinterface

// File: rtl/mode_coord_ctrl.sv
// Input-mode coordinator: turns keypad, ultrasonic and joystick events into a
// committed (x,y) target in the 0..9 grid, one cycle after each strobe.
//
// state  | meaning
// SELECT | waiting for A/B/C to pick an input source; x=y=F
// ULTRA  | x follows the quantized, debounced ultrasonic distance; y=0
// KEYB   | two-digit keypad entry, committed with E
// ANALOG | x/y follow the joystick ADC top nibbles
module mode_coord_ctrl #(
  parameter int unsigned STABLE_N = 3,
  parameter int unsigned US_SHIFT = 4
) (
  input logic        clk,
  input logic        reset,
  mode_coord_if.slave bus
);

  typedef enum logic [1:0] {
    S_SELECT = 2'b00,
    S_ULTRA  = 2'b01,
    S_KEYB   = 2'b10,
    S_ANALOG = 2'b11
  } state_t;

  localparam logic [3:0] KEY_A  = 4'hA;
  localparam logic [3:0] KEY_B  = 4'hB;
  localparam logic [3:0] KEY_C  = 4'hC;
  localparam logic [3:0] KEY_E  = 4'hE;
  localparam logic [3:0] KEY_F  = 4'hF;
  localparam logic [3:0] NONE   = 4'hF;
  localparam logic [2:0] STABLE = 3'(STABLE_N);

  state_t     state_q;
  logic [3:0] x_q, y_q;
  logic       cv_q;
  logic [1:0] idx_q;
  logic [2:0] run_q;
  logic [3:0] prev_q;

  logic [7:0] us_shr;
  logic [3:0] q_us, ax, ay;
  logic [2:0] run_next;
  logic       unused_adc_low;

  assign us_shr = bus.us_dist >> US_SHIFT;
  assign q_us   = (us_shr > 8'd9) ? 4'd9 : us_shr[3:0];
  assign ax     = (bus.adc_x[11:8] > 4'd9) ? 4'd9 : bus.adc_x[11:8];
  assign ay     = (bus.adc_y[11:8] > 4'd9) ? 4'd9 : bus.adc_y[11:8];
  assign unused_adc_low = ^{bus.adc_x[7:0], bus.adc_y[7:0]};

  // Run length including the current sample; saturates so a long steady run
  // cannot wrap and re-trigger.
  always_comb begin
    run_next = 3'd1;
    if (q_us == prev_q)
      run_next = (run_q >= STABLE) ? STABLE : run_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SELECT;
      x_q     <= NONE;
      y_q     <= NONE;
      cv_q    <= 1'b0;
      idx_q   <= 2'd0;
      run_q   <= 3'd0;
      prev_q  <= NONE;
    end else begin
      cv_q <= 1'b0;
      if (bus.key_valid) begin
        // A key always wins; any coincident sample is dropped.
        if (state_q == S_SELECT) begin
          if (bus.key_code == KEY_A || bus.key_code == KEY_B || bus.key_code == KEY_C) begin
            state_q <= (bus.key_code == KEY_A) ? S_ULTRA :
                       (bus.key_code == KEY_B) ? S_KEYB : S_ANALOG;
            x_q    <= NONE;
            y_q    <= NONE;
            idx_q  <= 2'd0;
            run_q  <= 3'd0;
            prev_q <= NONE;
          end
        end else if (bus.key_code == KEY_F) begin
          state_q <= S_SELECT;
          x_q     <= NONE;
          y_q     <= NONE;
          idx_q   <= 2'd0;
          run_q   <= 3'd0;
          prev_q  <= NONE;
        end else if (state_q == S_KEYB) begin
          if (bus.key_code <= 4'd9) begin
            if (idx_q == 2'd0) begin
              x_q   <= bus.key_code;
              y_q   <= NONE;
              idx_q <= 2'd1;
            end else if (idx_q == 2'd1) begin
              y_q   <= bus.key_code;
              idx_q <= 2'd2;
            end
          end else if (bus.key_code == KEY_E && idx_q == 2'd2) begin
            cv_q  <= 1'b1;
            idx_q <= 2'd0;
          end
        end
      end else if (bus.us_valid && state_q == S_ULTRA) begin
        run_q  <= run_next;
        prev_q <= q_us;
        if (run_next == STABLE && q_us != x_q) begin
          x_q  <= q_us;
          y_q  <= 4'd0;
          cv_q <= 1'b1;
        end
      end else if (bus.adc_valid && state_q == S_ANALOG) begin
        x_q <= ax;
        y_q <= ay;
        if ({ax, ay} != {x_q, y_q})
          cv_q <= 1'b1;
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.coord_valid = cv_q;

endmodule

// File: tb/tb_mode_coord_ctrl.sv
// Directed bench for mode_coord_ctrl: hand-computed outputs checked one cycle
// after each strobe.
module tb_mode_coord_ctrl;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mode_coord_if bus ();

  mode_coord_ctrl #(.STABLE_N(3), .US_SHIFT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.key_valid = 1'b0; bus.key_code = 4'h0;
    bus.us_valid  = 1'b0; bus.us_dist  = 8'd0;
    bus.adc_valid = 1'b0; bus.adc_x = 12'd0; bus.adc_y = 12'd0;
  endtask

  // Each driver strobes for one cycle and returns at the following negedge,
  // where the registered result of the strobe is visible.
  task automatic send_key(input logic [3:0] k);
    @(negedge clk); bus.key_valid = 1'b1; bus.key_code = k;
    @(negedge clk); idle_inputs();
  endtask

  task automatic send_us(input logic [7:0] d);
    @(negedge clk); bus.us_valid = 1'b1; bus.us_dist = d;
    @(negedge clk); idle_inputs();
  endtask

  task automatic send_adc(input logic [11:0] ax, input logic [11:0] ay);
    @(negedge clk); bus.adc_valid = 1'b1; bus.adc_x = ax; bus.adc_y = ay;
    @(negedge clk); idle_inputs();
  endtask

  task automatic send_key_us(input logic [3:0] k, input logic [7:0] d);
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key_code = k;
    bus.us_valid  = 1'b1; bus.us_dist  = d;
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL rst_state got %0h exp 0", bus.state); end
    vectors++; if (bus.x !== 4'hF) begin miscompares++; $display("FAIL rst_x got %0h exp F", bus.x); end
    vectors++; if (bus.y !== 4'hF) begin miscompares++; $display("FAIL rst_y got %0h exp F", bus.y); end
    vectors++; if (bus.coord_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cv got %0b exp 0", bus.coord_valid); end
  endtask

  task automatic test_select_ignores();
    send_key(4'h5);
    send_us(8'd50);
    send_adc(12'h345, 12'h678);
    send_key(4'hE);
    send_key(4'hF);
    send_key(4'hD);
    vectors++; if (bus.state !== 2'b00) begin miscompares++; $display("FAIL sel_state got %0h exp 0", bus.state); end
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {4'hF, 4'hF, 1'b0}) begin miscompares++; $display("FAIL sel_xycv got %0h exp 1fe", {bus.x, bus.y, bus.coord_valid}); end
  endtask

  task automatic test_keyb();
    send_key(4'hB);
    vectors++; if ({bus.state, bus.x, bus.y} !== {2'b10, 4'hF, 4'hF}) begin miscompares++; $display("FAIL kb_enter got %0h exp 2ff", {bus.state, bus.x, bus.y}); end
    send_key(4'h3);
    vectors++; if ({bus.x, bus.y} !== 8'h3F) begin miscompares++; $display("FAIL kb_x got %0h exp 3f", {bus.x, bus.y}); end
    send_key(4'h7);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h37, 1'b0}) begin miscompares++; $display("FAIL kb_y got %0h exp 06e", {bus.x, bus.y, bus.coord_valid}); end
    send_key(4'h8);
    send_key(4'hA);
    vectors++; if ({bus.state, bus.x, bus.y} !== {2'b10, 8'h37}) begin miscompares++; $display("FAIL kb_ignore got %0h exp 237", {bus.state, bus.x, bus.y}); end
    send_key(4'hE);
    vectors++; if (bus.coord_valid !== 1'b1) begin miscompares++; $display("FAIL kb_pulse got %0b exp 1", bus.coord_valid); end
    vectors++; if ({bus.x, bus.y} !== 8'h37) begin miscompares++; $display("FAIL kb_commit got %0h exp 37", {bus.x, bus.y}); end
    @(negedge clk);
    vectors++; if (bus.coord_valid !== 1'b0) begin miscompares++; $display("FAIL kb_pulse_end got %0b exp 0", bus.coord_valid); end
    send_key(4'hE);
    vectors++; if (bus.coord_valid !== 1'b0) begin miscompares++; $display("FAIL kb_e_idx0 got %0b exp 0", bus.coord_valid); end
  endtask

  task automatic test_keyb_partial();
    send_key(4'h4);
    vectors++; if ({bus.x, bus.y} !== 8'h4F) begin miscompares++; $display("FAIL kp_x got %0h exp 4f", {bus.x, bus.y}); end
    send_key(4'hE);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h4F, 1'b0}) begin miscompares++; $display("FAIL kp_e_idx1 got %0h exp 09e", {bus.x, bus.y, bus.coord_valid}); end
    send_key(4'hF);
    vectors++; if ({bus.state, bus.x, bus.y} !== {2'b00, 8'hFF}) begin miscompares++; $display("FAIL kp_esc got %0h exp 0ff", {bus.state, bus.x, bus.y}); end
  endtask

  task automatic test_ultra();
    send_key(4'hA);
    vectors++; if (bus.state !== 2'b01) begin miscompares++; $display("FAIL us_state got %0h exp 1", bus.state); end
    send_us(8'd50);
    send_us(8'd52);
    vectors++; if ({bus.x, bus.coord_valid} !== {4'hF, 1'b0}) begin miscompares++; $display("FAIL us_early got %0h exp 1e", {bus.x, bus.coord_valid}); end
    send_us(8'd55);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h30, 1'b1}) begin miscompares++; $display("FAIL us_commit got %0h exp 061", {bus.x, bus.y, bus.coord_valid}); end
    send_us(8'd50);
    vectors++; if (bus.coord_valid !== 1'b0) begin miscompares++; $display("FAIL us_same got %0b exp 0", bus.coord_valid); end
    send_us(8'd80);
    vectors++; if (bus.coord_valid !== 1'b0) begin miscompares++; $display("FAIL us_chg got %0b exp 0", bus.coord_valid); end
    send_us(8'd50);
    vectors++; if ({bus.x, bus.coord_valid} !== {4'h3, 1'b0}) begin miscompares++; $display("FAIL us_back got %0h exp 06", {bus.x, bus.coord_valid}); end
    send_adc(12'hFFF, 12'hFFF);
    send_key(4'h6);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h30, 1'b0}) begin miscompares++; $display("FAIL us_foreign got %0h exp 060", {bus.x, bus.y, bus.coord_valid}); end
    // 250 cm saturates to q=9; a digit key collides with one sample and drops it.
    send_us(8'd250);
    send_us(8'd250);
    send_key_us(4'h1, 8'd250);
    vectors++; if ({bus.x, bus.coord_valid} !== {4'h3, 1'b0}) begin miscompares++; $display("FAIL us_drop got %0h exp 06", {bus.x, bus.coord_valid}); end
    send_us(8'd250);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h90, 1'b1}) begin miscompares++; $display("FAIL us_sat got %0h exp 121", {bus.x, bus.y, bus.coord_valid}); end
  endtask

  task automatic test_coincident_escape();
    send_us(8'd80);
    send_us(8'd80);
    send_key_us(4'hF, 8'd80);
    vectors++; if ({bus.state, bus.x, bus.y, bus.coord_valid} !== {2'b00, 8'hFF, 1'b0}) begin miscompares++; $display("FAIL esc_us got %0h exp 1fe", {bus.state, bus.x, bus.y, bus.coord_valid}); end
    send_key(4'hA);
    send_us(8'd80);
    send_us(8'd80);
    vectors++; if ({bus.x, bus.coord_valid} !== {4'hF, 1'b0}) begin miscompares++; $display("FAIL esc_cleared got %0h exp 1e", {bus.x, bus.coord_valid}); end
    send_key(4'hF);
  endtask

  task automatic test_analog();
    send_key(4'hC);
    vectors++; if ({bus.state, bus.x, bus.y} !== {2'b11, 8'hFF}) begin miscompares++; $display("FAIL an_enter got %0h exp 3ff", {bus.state, bus.x, bus.y}); end
    send_adc(12'hFFF, 12'h200);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h92, 1'b1}) begin miscompares++; $display("FAIL an_first got %0h exp 125", {bus.x, bus.y, bus.coord_valid}); end
    send_adc(12'hFFF, 12'h200);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h92, 1'b0}) begin miscompares++; $display("FAIL an_repeat got %0h exp 124", {bus.x, bus.y, bus.coord_valid}); end
    send_adc(12'h3AB, 12'h9CD);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h39, 1'b1}) begin miscompares++; $display("FAIL an_move got %0h exp 073", {bus.x, bus.y, bus.coord_valid}); end
    send_adc(12'h345, 12'hA00);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h39, 1'b0}) begin miscompares++; $display("FAIL an_clamp got %0h exp 072", {bus.x, bus.y, bus.coord_valid}); end
    send_us(8'd30);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'h39, 1'b0}) begin miscompares++; $display("FAIL an_foreign got %0h exp 072", {bus.x, bus.y, bus.coord_valid}); end
    send_key(4'hF);
  endtask

  task automatic test_reset_mid_entry();
    send_key(4'hB);
    send_key(4'h1);
    send_key(4'h2);
    @(negedge clk);
    reset = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'hE;
    @(negedge clk);
    reset = 1'b0; idle_inputs();
    vectors++; if ({bus.state, bus.x, bus.y, bus.coord_valid} !== {2'b00, 8'hFF, 1'b0}) begin miscompares++; $display("FAIL rst_mid got %0h exp 1fe", {bus.state, bus.x, bus.y, bus.coord_valid}); end
    @(negedge clk);
    vectors++; if (bus.coord_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_late got %0b exp 0", bus.coord_valid); end
    send_key(4'hB);
    send_key(4'hE);
    vectors++; if ({bus.x, bus.y, bus.coord_valid} !== {8'hFF, 1'b0}) begin miscompares++; $display("FAIL rst_discard got %0h exp 1fe", {bus.x, bus.y, bus.coord_valid}); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_select_ignores();
    test_keyb();
    test_keyb_partial();
    test_ultra();
    test_coincident_escape();
    test_analog();
    test_reset_mid_entry();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
